// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one byte-enabled
// write port, optional zero register and write bypass, plus a pending scoreboard.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr3,
  input  logic [DATA_W-1:0]   data3,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [ADDR_W-1:0]   addr2,
  output logic [DATA_W-1:0]   rdout1,
  output logic [DATA_W-1:0]   rdout2,
  input  logic                rsv,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                busy1,
  output logic                busy2,
  output logic [ADDR_W:0]     busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Writes and reserves to the hardwired zero register are dropped; reset masks both.
  always_comb begin
    wr_ok   = wr && !rst && !((ZERO_REG != 0) && (addr3 == '0));
    rsv_ok  = rsv && !((ZERO_REG != 0) && (rsv_addr == '0));
    cnt_inc = rsv_ok && !pend[rsv_addr];
    cnt_dec = wr && pend[addr3] && !(rsv_ok && (rsv_addr == addr3));
  end

  // Register array with per-byte write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i]) regs[addr3][8*i +: 8] <= data3[8*i +: 8];
      end
    end
  end

  // Scoreboard: the reserve is applied after the clear so a new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr)     pend[addr3]    <= 1'b0;
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
      busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  // Read ports with optional byte-merged bypass of the in-flight write.
  always_comb begin
    rdout1 = regs[addr1];
    rdout2 = regs[addr2];
    if ((BYPASS != 0) && wr_ok) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i] && (addr1 == addr3)) rdout1[8*i +: 8] = data3[8*i +: 8];
        if (be[i] && (addr2 == addr3)) rdout2[8*i +: 8] = data3[8*i +: 8];
      end
    end
    if ((ZERO_REG != 0) && (addr1 == '0)) rdout1 = '0;
    if ((ZERO_REG != 0) && (addr2 == '0)) rdout2 = '0;
  end

  // Busy flags; a same-cycle clearing write hides the pending bit when bypassing.
  always_comb begin
    busy1 = pend[addr1];
    busy2 = pend[addr2];
    if ((BYPASS != 0) && wr && !rst) begin
      if ((addr3 == addr1) && !(rsv && (rsv_addr == addr1))) busy1 = 1'b0;
      if ((addr3 == addr2) && !(rsv && (rsv_addr == addr2))) busy2 = 1'b0;
    end
    if ((ZERO_REG != 0) && (addr1 == '0)) busy1 = 1'b0;
    if ((ZERO_REG != 0) && (addr2 == '0)) busy2 = 1'b0;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised MIPS-style register file: two combinational read ports, one clocked write port with byte enables, optional hardwired zero register, and optional same-cycle write-to-read bypass. Adds a per-register pending (scoreboard) bit array plus a pending counter so the decode stage can detect load-use hazards. Sits between decode (reads, reserve) and writeback (write) in the 32-bit datapath.

Parameters:
DATA_W, 32, register width in bits; multiple of 8.
ADDR_W, 5, address width; depth = 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads 0, and writes/reserves to it are ignored.
BYPASS, 1, 1 = a write in the current cycle is visible on the read ports in the same cycle.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
wr  in  1  write enable.
addr3  in  ADDR_W  write address.
data3  in  DATA_W  write data.
be  in  DATA_W/8  byte enables for the write; bit i covers data3[8i+7:8i].
addr1  in  ADDR_W  read port 1 address.
addr2  in  ADDR_W  read port 2 address.
rdout1  out  DATA_W  read port 1 data.
rdout2  out  DATA_W  read port 2 data.
rsv  in  1  reserve: mark rsv_addr pending.
rsv_addr  in  ADDR_W  register to reserve.
busy1  out  1  addr1 is pending.
busy2  out  1  addr2 is pending.
busy_cnt  out  ADDR_W+1  number of pending registers.

Behaviour:
- Reset (async, rst=1): all registers = 0, all pending bits = 0, busy_cnt = 0; holds while rst high; rdout/busy outputs follow the cleared state combinationally.
- Write: at posedge with wr=1, reg[addr3] byte i <= data3 byte i where be[i]=1; other bytes kept. be=0 -> no change. ZERO_REG=1 and addr3=0 -> write ignored.
- Read: combinational, zero latency. rdoutN = reg[addrN]. ZERO_REG=1 and addrN=0 -> 0 regardless of anything.
- Bypass (BYPASS=1): if wr=1, addrN=addr3, and the write is not ignored, rdoutN = byte-merged value (data3 bytes where be=1, reg bytes elsewhere). BYPASS=0: rdoutN shows old value until the edge.
- Both read ports may address the same register; both return identical data.
- Pending set: at posedge with rsv=1, pend[rsv_addr] <= 1 (ignored for reg 0 when ZERO_REG=1).
- Pending clear: at posedge with wr=1, pend[addr3] <= 0 (any be value, including 0).
- Simultaneous rsv and wr to the same address: reserve wins; pend stays/becomes 1 (new producer issued).
- Simultaneous rsv and wr to different addresses: both take effect.
- busy_cnt: incremented only on a 0->1 pend transition, decremented only on a 1->0 transition; both in the same cycle -> net unchanged. Reserving an already-pending register or clearing a non-pending one leaves count unchanged. busy_cnt always equals popcount(pend); never wraps (max 2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG=1).
- busyN = pend[addrN], except with BYPASS=1 it reads 0 when a clearing write to addrN occurs this cycle and no same-address reserve occurs. Reg 0 with ZERO_REG=1 -> busyN = 0.
- Reset asserted mid-operation overrides any concurrent wr/rsv; first edge after deassertion behaves normally.

Test Plan:
- Reset: assert rst with wr=1, addr3=5, data3=0x1234 -> after release rdout1(addr1=5)=0, busy_cnt=0.
- Write/read: wr=1, addr3=10, data3=0x0000FFFF, be=4'b1111; next cycle wr=0, addr1=10 -> rdout1=0x0000FFFF; write 0x0000AAAA to 31, addr1=31, addr2=10 -> rdout1=0x0000AAAA, rdout2=0x0000FFFF.
- Byte enables + zero reg: reg14=0x11223344, write data3=0xAABBCCDD, be=4'b0101 -> reg14=0x11BB33DD; write 0xFFFFFFFF to reg 0 -> rdout=0.
- Bypass: wr=1, addr3=1, data3=0x8888, addr1=1 same cycle -> rdout1=0x8888 before the edge (BYPASS=1); old value with BYPASS=0.
- Scoreboard: rsv 3, then rsv 7 -> busy_cnt=2, busy1(addr1=3)=1; wr addr3=3 -> busy_cnt=1; rsv 7 again -> busy_cnt=1; rsv 0 -> busy_cnt unchanged.
- Collision: reg 4 pending, rsv=1, rsv_addr=4, wr=1, addr3=4 same edge -> pend[4]=1, busy_cnt unchanged, data written.
